mem_ptr_unit: RTL and testbench

Holds the X, Y, Z and stack pointers for the memory stage and applies the auto-increment/decrement addressing modes. It sits directly upstream of the memory address select mux and drives its `x_ptr`, `y_ptr`, `z_ptr` and `stack_ptr` inputs with the effective address for the current cycle. It also accepts byte and word writes from writeback, because X/Y/Z alias register pairs. Pointer updates are registered; effective addresses are combinational.

---
 rtl/mem_ptr_unit.sv | 106 ++++++++++
 tb/tb_mem_ptr_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_ptr_unit.sv
// X/Y/Z/SP pointer file with auto-inc/dec addressing; effective addresses are combinational, updates registered.
// Optional stack fault detection is built only when MEM_PTR_STACK_CHECK_EN is defined.
module mem_ptr_unit #(
  parameter logic [15:0] SP_RESET    = 16'h08FF,
  parameter logic [15:0] STACK_LIMIT = 16'h0100
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall,
  input  logic [1:0]  ptr_sel,
  input  logic [2:0]  ptr_op,
  input  logic        wr_en,
  input  logic [1:0]  wr_sel,
  input  logic [1:0]  wr_half,
  input  logic [15:0] wr_data,
  input  logic        ovf_clr,
  output logic [15:0] x_ptr,
  output logic [15:0] y_ptr,
  output logic [15:0] z_ptr,
  output logic [15:0] stack_ptr,
  output logic        stack_ovf
);

  typedef enum logic [2:0] {
    OP_NONE     = 3'b000,
    OP_POST_INC = 3'b001,
    OP_POST_DEC = 3'b010,
    OP_PRE_INC  = 3'b011,
    OP_PRE_DEC  = 3'b100
  } ptr_op_t;

  // Index 0 is SP so the array lines up with the ptr_sel/wr_sel encoding.
  logic [15:0] ptr_q   [4];
  logic [15:0] ptr_nxt [4];
  logic [15:0] eff     [4];
  logic [3:0]  wr_hit;
  logic [3:0]  upd_hit;
  logic        op_inc;
  logic        op_dec;
  logic        op_pre;
  logic [15:0] upd_val;

  always_comb begin
    op_inc  = (ptr_op == OP_POST_INC) || (ptr_op == OP_PRE_INC);
    op_dec  = (ptr_op == OP_POST_DEC) || (ptr_op == OP_PRE_DEC);
    op_pre  = (ptr_op == OP_PRE_INC)  || (ptr_op == OP_PRE_DEC);
    upd_val = op_dec ? (ptr_q[ptr_sel] - 16'h0001) : (ptr_q[ptr_sel] + 16'h0001);
    wr_hit  = '0;
    upd_hit = '0;
    for (int i = 0; i < 4; i++) begin
      // A write of no bytes is not a write, so it does not cancel an update.
      wr_hit[i]  = wr_en && (wr_sel == 2'(i)) && (wr_half != 2'b00);
      upd_hit[i] = (op_inc || op_dec) && (ptr_sel == 2'(i)) && !wr_hit[i];
      eff[i]     = (op_pre && (ptr_sel == 2'(i))) ? upd_val : ptr_q[i];
      ptr_nxt[i] = ptr_q[i];
      if (wr_hit[i]) begin
        if (wr_half[0]) ptr_nxt[i][7:0]  = wr_data[7:0];
        if (wr_half[1]) ptr_nxt[i][15:8] = wr_data[15:8];
      end else if (upd_hit[i]) begin
        ptr_nxt[i] = upd_val;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q[0] <= SP_RESET;
      ptr_q[1] <= 16'h0000;
      ptr_q[2] <= 16'h0000;
      ptr_q[3] <= 16'h0000;
    end else if (!stall) begin
      for (int i = 0; i < 4; i++) ptr_q[i] <= ptr_nxt[i];
    end
  end

  assign stack_ptr = eff[0];
  assign x_ptr     = eff[1];
  assign y_ptr     = eff[2];
  assign z_ptr     = eff[3];

`ifdef MEM_PTR_STACK_CHECK_EN
  logic ovf_q;
  logic ovf_set;

  // Underflow below the limit on a decrement, or wrap to zero on an increment.
  assign ovf_set = upd_hit[0] &&
                   ((op_dec && (upd_val < STACK_LIMIT)) ||
                    (op_inc && (ptr_q[0] == 16'hFFFF)));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else if (!stall) begin
      if (ovf_set)      ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  assign stack_ovf = ovf_q;
`else
  logic unused_check;
  assign unused_check = ^{ovf_clr, STACK_LIMIT};
  assign stack_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_ptr_unit.sv
// Directed self-checking bench for mem_ptr_unit; stack-fault expectations follow MEM_PTR_STACK_CHECK_EN.
module tb_mem_ptr_unit;

  logic        clock;
  logic        reset_n;
  logic        stall;
  logic [1:0]  ptr_sel;
  logic [2:0]  ptr_op;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [1:0]  wr_half;
  logic [15:0] wr_data;
  logic        ovf_clr;
  logic [15:0] x_ptr;
  logic [15:0] y_ptr;
  logic [15:0] z_ptr;
  logic [15:0] stack_ptr;
  logic        stack_ovf;

  int checks = 0;
  int errors = 0;

`ifdef MEM_PTR_STACK_CHECK_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  localparam logic [1:0] SEL_SP = 2'b00, SEL_X = 2'b01, SEL_Y = 2'b10, SEL_Z = 2'b11;
  localparam logic [2:0] NONE = 3'b000, POST_INC = 3'b001, POST_DEC = 3'b010,
                         PRE_INC = 3'b011, PRE_DEC = 3'b100;

  mem_ptr_unit #(.SP_RESET(16'h08FF), .STACK_LIMIT(16'h0100)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .stall     (stall),
    .ptr_sel   (ptr_sel),
    .ptr_op    (ptr_op),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_half   (wr_half),
    .wr_data   (wr_data),
    .ovf_clr   (ovf_clr),
    .x_ptr     (x_ptr),
    .y_ptr     (y_ptr),
    .z_ptr     (z_ptr),
    .stack_ptr (stack_ptr),
    .stack_ovf (stack_ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change here, away from the edge.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic idle();
    stall = 0; ptr_op = NONE; ptr_sel = SEL_SP;
    wr_en = 0; wr_sel = SEL_SP; wr_half = 2'b00; wr_data = 16'h0000; ovf_clr = 0;
  endtask

  task automatic write_full(input logic [1:0] sel, input logic [15:0] val);
    idle();
    wr_en = 1; wr_sel = sel; wr_half = 2'b11; wr_data = val;
    tick();
    idle();
  endtask

  initial begin
    reset_n = 0;
    idle();
    #12;
    check("rst_x", x_ptr, 16'h0000);
    check("rst_y", y_ptr, 16'h0000);
    check("rst_z", z_ptr, 16'h0000);
    check("rst_sp", stack_ptr, 16'h08FF);
    check("rst_ovf", {15'b0, stack_ovf}, 16'h0000);
    reset_n = 1;
    tick();

    // X post-increment
    write_full(SEL_X, 16'h1234);
    ptr_sel = SEL_X; ptr_op = POST_INC; #1;
    check("x_postinc_now", x_ptr, 16'h1234);
    tick(); idle(); #1;
    check("x_postinc_next", x_ptr, 16'h1235);

    // Y pre-decrement through zero; other outputs stay raw
    ptr_sel = SEL_Y; ptr_op = PRE_DEC; #1;
    check("y_predec_now", y_ptr, 16'hFFFF);
    check("x_unselected", x_ptr, 16'h1235);
    tick(); idle(); #1;
    check("y_predec_next", y_ptr, 16'hFFFF);

    // Push then pop
    ptr_sel = SEL_SP; ptr_op = POST_DEC; #1;
    check("push_now", stack_ptr, 16'h08FF);
    tick(); idle(); #1;
    check("push_next", stack_ptr, 16'h08FE);
    ptr_sel = SEL_SP; ptr_op = PRE_INC; #1;
    check("pop_now", stack_ptr, 16'h08FF);
    tick(); idle(); #1;
    check("pop_next", stack_ptr, 16'h08FF);

    // Byte write, then collision with a post-increment on the same pointer
    write_full(SEL_Z, 16'hABCD);
    wr_en = 1; wr_sel = SEL_Z; wr_half = 2'b01; wr_data = 16'h0012;
    tick(); idle(); #1;
    check("z_low_byte", z_ptr, 16'hAB12);
    write_full(SEL_Z, 16'hABCD);
    ptr_sel = SEL_Z; ptr_op = POST_INC;
    wr_en = 1; wr_sel = SEL_Z; wr_half = 2'b10; wr_data = 16'h5600; #1;
    check("collide_now", z_ptr, 16'hABCD);
    tick(); idle(); #1;
    check("collide_next", z_ptr, 16'h56CD);

    // Write and update on different pointers both land
    ptr_sel = SEL_X; ptr_op = PRE_INC;
    wr_en = 1; wr_sel = SEL_Y; wr_half = 2'b11; wr_data = 16'h4242; #1;
    check("split_x_now", x_ptr, 16'h1236);
    tick(); idle(); #1;
    check("split_x_next", x_ptr, 16'h1236);
    check("split_y_next", y_ptr, 16'h4242);

    // Stall holds registers and blocks writes
    write_full(SEL_X, 16'h0010);
    stall = 1; ptr_sel = SEL_X; ptr_op = POST_INC;
    wr_en = 1; wr_sel = SEL_Z; wr_half = 2'b11; wr_data = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      check("stall_x", x_ptr, 16'h0010);
    end
    check("stall_z", z_ptr, 16'h56CD);
    ptr_op = PRE_INC; #1;
    check("stall_pre_view", x_ptr, 16'h0011);
    wr_en = 0; stall = 0; ptr_op = POST_INC;
    tick(); idle(); #1;
    check("unstall_x", x_ptr, 16'h0011);

    // Stack limit boundary: landing exactly on the limit is legal
    write_full(SEL_SP, 16'h0101);
    ptr_sel = SEL_SP; ptr_op = POST_DEC;
    tick(); idle(); #1;
    check("sp_at_limit", stack_ptr, 16'h0100);
    check("ovf_at_limit", {15'b0, stack_ovf}, 16'h0000);
    ptr_sel = SEL_SP; ptr_op = POST_DEC;
    tick(); idle(); #1;
    check("sp_below_limit", stack_ptr, 16'h00FF);
    check("ovf_below_limit", {15'b0, stack_ovf}, {15'b0, OVF_ON});
    ovf_clr = 1;
    tick(); idle(); #1;
    check("ovf_cleared", {15'b0, stack_ovf}, 16'h0000);
    ptr_sel = SEL_SP; ptr_op = POST_DEC; ovf_clr = 1;
    tick(); idle(); #1;
    check("ovf_set_beats_clr", {15'b0, stack_ovf}, {15'b0, OVF_ON});
    ovf_clr = 1;
    tick(); idle();
    write_full(SEL_SP, 16'hFFFF);
    ptr_sel = SEL_SP; ptr_op = PRE_INC; #1;
    check("pop_wrap_now", stack_ptr, 16'h0000);
    tick(); idle(); #1;
    check("pop_wrap_sp", stack_ptr, 16'h0000);
    check("pop_wrap_ovf", {15'b0, stack_ovf}, {15'b0, OVF_ON});

    // Asynchronous reset mid-run, with and without a PRE op pending
    write_full(SEL_X, 16'h7777);
    #1; reset_n = 0; #1;
    check("arst_x", x_ptr, 16'h0000);
    check("arst_sp", stack_ptr, 16'h08FF);
    check("arst_ovf", {15'b0, stack_ovf}, 16'h0000);
    ptr_sel = SEL_SP; ptr_op = PRE_DEC; #1;
    check("arst_sp_predec", stack_ptr, 16'h08FE);
    tick(); #1;
    check("arst_hold", stack_ptr, 16'h08FE);
    idle(); reset_n = 1;
    tick(); #1;
    check("post_rst_sp", stack_ptr, 16'h08FF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
